inst_loader: RTL and testbench
==============================

Name: inst_loader

Overview:
- Program loader that writes the instruction memory, which the fetch stage only reads.
- Receives a byte stream over a valid/ready handshake, for example from a UART receiver.
- Assembles little-endian 32-bit instruction words and issues one write per word to the instruction memory write port.
- Holds the fetch stage (CpuHold drives the PC enable low) while a load is in progress; releases it only after a checksum-verified load.

Parameters:
- BASE_ADDR, 32'h00000000, byte address of the first instruction written.
- MAX_WORDS, 64, maximum word count accepted; a larger header count is an error.

Ports:
- Clk  input  1  system clock, rising edge.
- Clrn  input  1  asynchronous active-low reset/clear.
- Start  input  1  single-cycle pulse; begins a load from IDLE, DONE or ERR.
- RxData  input  8  incoming stream byte.
- RxValid  input  1  RxData is valid; source holds byte and valid until accepted.
- RxReady  output  1  loader accepts a byte this cycle.
- WrEn  output  1  instruction memory write strobe, one cycle per word.
- WrAddr  output  32  instruction memory byte address.
- WrData  output  32  instruction word to write.
- CpuHold  output  1  1 = fetch stage PC frozen.
- Done  output  1  sticky; load completed and checksum matched.
- Err  output  1  sticky; length overflow or checksum mismatch.

Behaviour:
- Stream format:
  - Count N, 16-bit, low byte first.
  - N×4 instruction bytes; each word is least-significant byte first.
  - One checksum byte, equal to the XOR of all instruction bytes (initial value 0x00; the length bytes are excluded).
- Handshake: a byte is accepted on a rising edge with RxValid=1 and RxReady=1.
- All outputs are registered.
- FSM states: IDLE, LEN0, LEN1, DATA, WRITE, CSUM, DONE, ERR.
- Reset (Clrn=0, asynchronous):
  - state=IDLE, RxReady=0, WrEn=0, WrAddr=BASE_ADDR, WrData=0.
  - CpuHold=0, Done=0, Err=0.
  - Word index, byte index and checksum are all cleared.
- IDLE:
  - Start → LEN0.
  - Next cycle: CpuHold=1, Done=0, Err=0, checksum=0, word index=0.
- RxReady: 1 in LEN0, LEN1, DATA and CSUM; 0 in IDLE, WRITE, DONE and ERR.
- LEN0 → LEN1 on accept; the accepted byte is N[7:0].
- LEN1, on accept the byte is N[15:8], then:
  - N > MAX_WORDS → ERR.
  - N == 0 → CSUM.
  - Otherwise → DATA.
- DATA:
  - Byte k (k = 0..3) goes to WrData[8k+7:8k] and is XORed into the checksum.
  - After the accept of byte 3 → WRITE.
- WRITE (exactly one cycle, no byte accepted):
  - WrEn=1, WrAddr = BASE_ADDR + 4×index (32-bit, wraps mod 2^32), WrData = assembled word.
  - WrEn therefore rises the cycle after the fourth byte's accept.
  - Then index+1: if it equals N → CSUM, else → DATA.
  - WrEn=0 in every other state.
- CSUM, on accept:
  - Byte == checksum → DONE: Done=1, CpuHold=0.
  - Otherwise → ERR: Err=1, CpuHold stays 1.
- DONE and ERR:
  - Hold until Start, which behaves as Start in IDLE and clears Done/Err.
  - Start is ignored in LEN0, LEN1, DATA, WRITE and CSUM.
- Backpressure: RxValid gaps stall the FSM indefinitely; no timeout.
- Reset mid-load: returns immediately to reset values. Words already written stay in memory; CpuHold drops to 0.
- WrAddr and WrData hold their last values when WrEn=0.

Test Plan:
- Nominal load:
  - Stimulus: Start, then bytes 02 00 13 00 00 00 93 80 10 00 10 with RxValid held high.
  - Expected: WrEn pulse with addr 0x00000000 / data 0x00000013, then addr 0x00000004 / data 0x00108093.
  - Final: Done=1, Err=0, CpuHold=0; exactly 2 WrEn cycles.
- Bad checksum:
  - Stimulus: same stream with last byte 11.
  - Expected: both writes occur, then Err=1, Done=0, CpuHold=1, RxReady=0.
  - A following Start clears Err.
- Empty program:
  - Stimulus: Start, then 00 00 00.
  - Expected: Done=1 with no WrEn pulse; CpuHold falls after the checksum accept.
- Length overflow (MAX_WORDS=64):
  - Stimulus: Start, then 41 00.
  - Expected: Err=1 one cycle after the second accept; RxReady=0; no WrEn.
- Backpressure/stall:
  - Stimulus: nominal stream with RxValid low on random cycles, and a byte presented during a WRITE cycle.
  - Expected: RxReady=0 in WRITE and the byte is accepted the next cycle. Writes and Done match the nominal case.
- Async reset mid-DATA:
  - Stimulus: assert Clrn=0 between clock edges after 2 data bytes.
  - Expected: RxReady, WrEn, CpuHold, Done and Err go to 0 without waiting for a clock edge.
  - After release, a fresh nominal load produces the nominal results.

Source files
------------

// File: rtl/inst_loader.sv
// Program loader: receives a byte stream (16-bit word count, little-endian
// instruction words, XOR checksum) over a valid/ready handshake and writes
// each assembled word to the instruction memory. The fetch stage is held
// for the whole load and released only once the checksum has matched.
module inst_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 64
) (
  input  logic        Clk,
  input  logic        Clrn,
  input  logic        Start,
  input  logic [7:0]  RxData,
  input  logic        RxValid,
  output logic        RxReady,
  output logic        WrEn,
  output logic [31:0] WrAddr,
  output logic [31:0] WrData,
  output logic        CpuHold,
  output logic        Done,
  output logic        Err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN0  = 3'd1,
    S_LEN1  = 3'd2,
    S_DATA  = 3'd3,
    S_WRITE = 3'd4,
    S_CSUM  = 3'd5,
    S_DONE  = 3'd6,
    S_ERR   = 3'd7
  } state_e;

  // Running checksum step: XOR of every instruction byte.
  function automatic logic [7:0] csum_update(input logic [7:0] csum,
                                             input logic [7:0] data);
    return csum ^ data;
  endfunction

  state_e      state_q, state_d;
  logic        rx_ready_q, rx_ready_d;
  logic        wr_en_q, wr_en_d;
  logic [31:0] wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic        cpu_hold_q, cpu_hold_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [15:0] count_q, count_d;
  logic [15:0] word_idx_q, word_idx_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [7:0]  csum_q, csum_d;
  // Lower three bytes of the word being assembled; the fourth byte is
  // combined with these directly into WrData on entry to WRITE.
  logic [23:0] word_q, word_d;

  logic        accept_s;
  logic [15:0] count_full_s;
  logic [15:0] idx_next_s;

  assign accept_s     = rx_ready_q & RxValid;
  assign count_full_s = {RxData, count_q[7:0]};
  assign idx_next_s   = word_idx_q + 16'd1;

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d    = state_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    cpu_hold_d = cpu_hold_q;
    done_d     = done_q;
    err_d      = err_q;
    count_d    = count_q;
    word_idx_d = word_idx_q;
    byte_idx_d = byte_idx_q;
    csum_d     = csum_q;
    word_d     = word_q;
    rx_ready_d = 1'b0;
    wr_en_d    = 1'b0;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (Start) begin
          state_d    = S_LEN0;
          cpu_hold_d = 1'b1;
          done_d     = 1'b0;
          err_d      = 1'b0;
          csum_d     = 8'h00;
          word_idx_d = 16'd0;
          byte_idx_d = 2'd0;
        end else begin
          state_d = state_q;
        end
      end
      S_LEN0: begin
        if (accept_s) begin
          count_d = {count_q[15:8], RxData};
          state_d = S_LEN1;
        end else begin
          state_d = S_LEN0;
        end
      end
      S_LEN1: begin
        if (accept_s) begin
          count_d = count_full_s;
          if ({16'd0, count_full_s} > MAX_WORDS) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else if (count_full_s == 16'd0) begin
            state_d = S_CSUM;
          end else begin
            state_d = S_DATA;
          end
        end else begin
          state_d = S_LEN1;
        end
      end
      S_DATA: begin
        if (accept_s) begin
          csum_d     = csum_update(csum_q, RxData);
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            // Last byte of the word: present the whole word for one write.
            wr_data_d = {RxData, word_q};
            wr_addr_d = BASE_ADDR + {14'd0, word_idx_q, 2'b00};
            state_d   = S_WRITE;
          end else begin
            word_d  = {RxData, word_q[23:8]};
            state_d = S_DATA;
          end
        end else begin
          state_d = S_DATA;
        end
      end
      S_WRITE: begin
        word_idx_d = idx_next_s;
        if (idx_next_s == count_q) begin
          state_d = S_CSUM;
        end else begin
          state_d = S_DATA;
        end
      end
      S_CSUM: begin
        if (accept_s) begin
          if (RxData == csum_q) begin
            state_d    = S_DONE;
            done_d     = 1'b1;
            cpu_hold_d = 1'b0;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end else begin
          state_d = S_CSUM;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Handshake and strobe are registered, so derive them from the state
    // being entered; they then line up with the state they belong to.
    case (state_d)
      S_LEN0, S_LEN1, S_DATA, S_CSUM: rx_ready_d = 1'b1;
      S_WRITE:                        wr_en_d    = 1'b1;
      default:                        rx_ready_d = 1'b0;
    endcase
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      state_q    <= S_IDLE;
      rx_ready_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= BASE_ADDR;
      wr_data_q  <= 32'h0000_0000;
      cpu_hold_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      count_q    <= 16'd0;
      word_idx_q <= 16'd0;
      byte_idx_q <= 2'd0;
      csum_q     <= 8'h00;
      word_q     <= 24'd0;
    end else begin
      state_q    <= state_d;
      rx_ready_q <= rx_ready_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      cpu_hold_q <= cpu_hold_d;
      done_q     <= done_d;
      err_q      <= err_d;
      count_q    <= count_d;
      word_idx_q <= word_idx_d;
      byte_idx_q <= byte_idx_d;
      csum_q     <= csum_d;
      word_q     <= word_d;
    end
  end

  assign RxReady = rx_ready_q;
  assign WrEn    = wr_en_q;
  assign WrAddr  = wr_addr_q;
  assign WrData  = wr_data_q;
  assign CpuHold = cpu_hold_q;
  assign Done    = done_q;
  assign Err     = err_q;

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader: directed and randomized byte streams
// checked against a stream-level reference model.
module tb_inst_loader;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int          MAXW = 64;

  logic        Clk = 1'b0;
  logic        Clrn = 1'b0;
  logic        Start = 1'b0;
  logic [7:0]  RxData = 8'h00;
  logic        RxValid = 1'b0;
  logic        RxReady, WrEn, CpuHold, Done, Err;
  logic [31:0] WrAddr, WrData;

  int checks = 0;
  int errors = 0;
  int gap_pct = 0;

  logic [31:0] got_addr[$], got_data[$];
  logic [31:0] exp_addr[$], exp_data[$];
  logic        exp_done, exp_err;
  logic [7:0]  stream[$];

  always #5 Clk = ~Clk;

  inst_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .Clk(Clk), .Clrn(Clrn), .Start(Start), .RxData(RxData),
    .RxValid(RxValid), .RxReady(RxReady), .WrEn(WrEn), .WrAddr(WrAddr),
    .WrData(WrData), .CpuHold(CpuHold), .Done(Done), .Err(Err)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Capture every write strobe; no byte may be accepted while writing.
  always @(negedge Clk) begin
    if (WrEn === 1'b1) begin
      got_addr.push_back(WrAddr);
      got_data.push_back(WrData);
      check("ready_in_write", {31'd0, RxReady}, 32'd0);
    end
  end

  // Reference model: decode the whole stream by its format rules.
  task automatic build_model(input logic [7:0] s[$]);
    int n;
    logic [7:0] x;
    exp_addr.delete();
    exp_data.delete();
    n = int'({s[1], s[0]});
    x = 8'h00;
    if (n > MAXW) begin
      exp_done = 1'b0;
      exp_err  = 1'b1;
      return;
    end
    for (int w = 0; w < n; w++) begin
      exp_addr.push_back(BASE + 32'(4 * w));
      exp_data.push_back({s[2+4*w+3], s[2+4*w+2], s[2+4*w+1], s[2+4*w]});
      for (int k = 0; k < 4; k++) x = x ^ s[2+4*w+k];
    end
    exp_done = (s[2+4*n] == x);
    exp_err  = !exp_done;
  endtask

  task automatic pulse_start();
    @(negedge Clk);
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
  endtask

  // Present one byte (after optional random idle cycles) and wait for accept.
  task automatic send_byte(input logic [7:0] b);
    int waited;
    @(negedge Clk);
    while (gap_pct != 0 && $urandom_range(99, 0) < gap_pct) begin
      RxValid = 1'b0;
      @(negedge Clk);
    end
    RxValid = 1'b1;
    RxData  = b;
    waited  = 0;
    while (RxReady !== 1'b1 && waited < 50) begin
      @(negedge Clk);
      waited++;
    end
    if (RxReady !== 1'b1) begin
      checks++;
      errors++;
      $error("FAIL handshake_timeout: RxReady observed %b expected 1", RxReady);
      RxValid = 1'b0;
      return;
    end
    @(posedge Clk);
    #1 RxValid = 1'b0;
  endtask

  task automatic run_load(input string tag, input logic [7:0] s[$]);
    build_model(s);
    got_addr.delete();
    got_data.delete();
    pulse_start();
    check({tag, "_start_hold"},  {31'd0, CpuHold}, 32'd1);
    check({tag, "_start_done"},  {31'd0, Done},    32'd0);
    check({tag, "_start_err"},   {31'd0, Err},     32'd0);
    check({tag, "_start_ready"}, {31'd0, RxReady}, 32'd1);
    foreach (s[i]) send_byte(s[i]);
    @(negedge Clk);
    check({tag, "_done"},  {31'd0, Done},    {31'd0, exp_done});
    check({tag, "_err"},   {31'd0, Err},     {31'd0, exp_err});
    check({tag, "_hold"},  {31'd0, CpuHold}, {31'd0, ~exp_done});
    check({tag, "_ready"}, {31'd0, RxReady}, 32'd0);
    check({tag, "_nwrites"}, 32'(got_addr.size()), 32'(exp_addr.size()));
    for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
      check({tag, "_addr"}, got_addr[i], exp_addr[i]);
      check({tag, "_data"}, got_data[i], exp_data[i]);
    end
  endtask

  task automatic set_nominal(input logic [7:0] last);
    stream = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
               8'h93, 8'h80, 8'h10, 8'h00, last};
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [7:0] x, b;

    // Reset values while Clrn is held low.
    repeat (2) @(negedge Clk);
    check("rst_ready", {31'd0, RxReady}, 32'd0);
    check("rst_wren",  {31'd0, WrEn},    32'd0);
    check("rst_addr",  WrAddr,           BASE);
    check("rst_data",  WrData,           32'd0);
    check("rst_hold",  {31'd0, CpuHold}, 32'd0);
    check("rst_done",  {31'd0, Done},    32'd0);
    check("rst_err",   {31'd0, Err},     32'd0);
    Clrn = 1'b1;
    repeat (2) @(negedge Clk);
    check("idle_ready", {31'd0, RxReady}, 32'd0);

    // Nominal, bad checksum (then Start clears Err), empty, overflow.
    set_nominal(8'h10);
    run_load("nominal", stream);
    set_nominal(8'h11);
    run_load("badcsum", stream);
    set_nominal(8'h10);
    run_load("after_err", stream);
    stream = '{8'h00, 8'h00, 8'h00};
    run_load("empty", stream);
    stream = '{8'h41, 8'h00};
    run_load("overflow", stream);

    // Backpressure with random valid gaps.
    gap_pct = 40;
    set_nominal(8'h10);
    run_load("stall", stream);
    gap_pct = 0;

    // Asynchronous reset after two data bytes.
    pulse_start();
    set_nominal(8'h10);
    for (int i = 0; i < 4; i++) send_byte(stream[i]);
    check("pre_rst_hold", {31'd0, CpuHold}, 32'd1);
    #2 Clrn = 1'b0;
    #1;
    check("arst_ready", {31'd0, RxReady}, 32'd0);
    check("arst_wren",  {31'd0, WrEn},    32'd0);
    check("arst_hold",  {31'd0, CpuHold}, 32'd0);
    check("arst_done",  {31'd0, Done},    32'd0);
    check("arst_err",   {31'd0, Err},     32'd0);
    @(negedge Clk);
    Clrn = 1'b1;
    run_load("post_rst", stream);

    // Largest accepted program.
    stream.delete();
    stream.push_back(8'(MAXW));
    stream.push_back(8'h00);
    x = 8'h00;
    for (int i = 0; i < 4 * MAXW; i++) begin
      b = 8'($urandom);
      stream.push_back(b);
      x = x ^ b;
    end
    stream.push_back(x);
    run_load("maxwords", stream);

    // Randomized programs, checksums and overflow counts.
    for (int r = 0; r < 10; r++) begin
      gap_pct = int'($urandom_range(40, 0));
      stream.delete();
      if ($urandom_range(4, 0) == 0) begin
        n = MAXW + 1 + int'($urandom_range(2000, 0));
        stream.push_back(8'(n));
        stream.push_back(8'(n >> 8));
      end else begin
        n = int'($urandom_range(6, 0));
        stream.push_back(8'(n));
        stream.push_back(8'h00);
        x = 8'h00;
        for (int i = 0; i < 4 * n; i++) begin
          b = 8'($urandom);
          stream.push_back(b);
          x = x ^ b;
        end
        if ($urandom_range(3, 0) == 0) x = x ^ 8'(1 + $urandom_range(254, 0));
        stream.push_back(x);
      end
      run_load("random", stream);
    end
    gap_pct = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
